bsg_fifo_1r1w_rolly_replay_ctrl: RTL

Read-side replay controller for a rolly FIFO (`bsg_fifo_1r1w_rolly` or equivalent) feeding a lossy, in-order link.
- Streams FIFO entries downstream speculatively, up to a bounded number outstanding.
- Commits each entry when the link acknowledges it.
- On a nack or timeout, rewinds the FIFO read pointer so unacknowledged entries replay after a backoff.
- Sits between the rolly FIFO read port and the link transmitter; the FIFO write side is untouched.

---
 rtl/bsg_fifo_1r1w_rolly_replay_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/bsg_fifo_1r1w_rolly_replay_ctrl.sv
// Read-side replay controller for a rolly FIFO feeding a lossy in-order link.
// Define BSG_FIFO_ROLLY_REPLAY_STATS_EN to build the saturating rewind counter behind replay_count_o.
module bsg_fifo_1r1w_rolly_replay_ctrl #(
    parameter int width_p           = 8,
    parameter int lg_size_p         = 3,
    parameter int max_outstanding_p = 2 ** lg_size_p,
    parameter int timeout_p         = 64,
    parameter int backoff_p         = 4,
    parameter int max_retries_p     = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,

    input  logic [width_p-1:0] fifo_data_i,
    input  logic               fifo_v_i,
    output logic               fifo_yumi_o,
    output logic               fifo_r_incr_o,
    output logic               fifo_r_rewind_o,

    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               ready_i,
    input  logic               ack_i,
    input  logic               nack_i,

    output logic               error_o,
    output logic [15:0]        replay_count_o
);

    localparam int out_width_lp   = $clog2(max_outstanding_p + 1);
    localparam int to_width_lp    = (timeout_p > 1) ? $clog2(timeout_p) : 1;
    localparam int bo_width_lp    = (backoff_p > 1) ? $clog2(backoff_p) : 1;
    localparam int retry_width_lp = $clog2(max_retries_p + 1);
    localparam int bo_last_lp     = (backoff_p > 0) ? backoff_p - 1 : 0;

    typedef enum logic [1:0] {eSend, eBackoff, eError} state_e;

    state_e                    state_r;
    logic [out_width_lp-1:0]   outstanding_r;
    logic [to_width_lp-1:0]    timeout_r;
    logic [bo_width_lp-1:0]    backoff_r;
    logic [retry_width_lp-1:0] retry_r;

    logic send_st;
    logic has_outstanding;
    logic ack_valid;
    logic timeout_hit;
    logic rewind;
    logic [retry_width_lp-1:0] retry_on_rewind;

    assign send_st         = (state_r == eSend);
    assign has_outstanding = (outstanding_r != '0);

    assign data_o = fifo_data_i;
    assign v_o    = fifo_v_i & send_st
                  & (outstanding_r < out_width_lp'(max_outstanding_p));

    // Acks only count against something actually in flight; in eError they are dropped.
    assign ack_valid   = ack_i & has_outstanding & (state_r != eError);
    assign timeout_hit = send_st & has_outstanding & ~ack_valid
                       & (timeout_r == to_width_lp'(timeout_p - 1));
    assign rewind      = (nack_i & (state_r != eBackoff)) | timeout_hit;

    assign fifo_yumi_o     = v_o & ready_i & ~rewind;
    assign fifo_r_incr_o   = ack_valid;
    assign fifo_r_rewind_o = rewind;
    assign error_o         = (state_r == eError);

    // An ack in the rewind cycle proves the link made progress, so the streak restarts at one.
    assign retry_on_rewind = ack_valid ? retry_width_lp'(1)
                                       : retry_r + retry_width_lp'(1);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r       <= eSend;
            outstanding_r <= '0;
            timeout_r     <= '0;
            backoff_r     <= '0;
            retry_r       <= '0;
        end else begin
            if (rewind)
                outstanding_r <= '0;
            else
                outstanding_r <= outstanding_r + out_width_lp'(fifo_yumi_o)
                                               - out_width_lp'(ack_valid);

            if (send_st && has_outstanding && !ack_valid && !rewind)
                timeout_r <= timeout_r + to_width_lp'(1);
            else
                timeout_r <= '0;

            if (state_r != eError) begin
                if (rewind)
                    retry_r <= retry_on_rewind;
                else if (ack_valid)
                    retry_r <= '0;
            end

            case (state_r)
                eSend: begin
                    if (rewind) begin
                        backoff_r <= '0;
                        if (retry_on_rewind >= retry_width_lp'(max_retries_p))
                            state_r <= eError;
                        else if (backoff_p == 0)
                            state_r <= eSend;
                        else
                            state_r <= eBackoff;
                    end
                end
                eBackoff: begin
                    if (backoff_r == bo_width_lp'(bo_last_lp))
                        state_r <= eSend;
                    else
                        backoff_r <= backoff_r + bo_width_lp'(1);
                end
                eError:   state_r <= eError;
                default:  state_r <= eSend;
            endcase
        end
    end

`ifdef BSG_FIFO_ROLLY_REPLAY_STATS_EN
    logic [15:0] replay_count_r;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            replay_count_r <= '0;
        else if (rewind && (replay_count_r != 16'hFFFF))
            replay_count_r <= replay_count_r + 16'd1;
    end

    assign replay_count_o = replay_count_r;
`else
    assign replay_count_o = '0;
`endif

    ack_needs_outstanding: assert property (@(posedge clk_i) disable iff (reset_i)
        !(ack_i && !has_outstanding && (state_r != eError)));

endmodule
